// File: rtl/alarm_ctrl.sv
// alarm_ctrl: button-driven digit entry, load strobes and ring/snooze sequencing for the alarm clock core.
module alarm_ctrl #(
    parameter int RING_CYCLES   = 60,
    parameter int SNOOZE_CYCLES = 300,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       btn_inc,
    input  logic       btn_arm,
    input  logic       btn_snooze,
    input  logic       alarm_in,
    output logic [1:0] hourIn1,
    output logic [3:0] hourIn0,
    output logic [3:0] minIn1,
    output logic [3:0] minIn0,
    output logic       ldTime,
    output logic       ldAlarm,
    output logic       alarmOn,
    output logic       buzzer,
    output logic [1:0] edit_mode,
    output logic [1:0] digit_sel
);
    typedef enum logic [2:0] {IDLE, EDIT_TIME, EDIT_ALARM, LOAD, RING, SNOOZE} state_t;

    localparam logic [CNT_W-1:0] RING_LD   = CNT_W'(RING_CYCLES - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       h1_q, h1_d;
    logic [3:0]       h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
    logic             ld_time_q, ld_time_d, ld_alarm_q, ld_alarm_d;
    logic             alarm_on_q, alarm_on_d, buzzer_q, buzzer_d;
    logic [1:0]       edit_mode_q, edit_mode_d, digit_sel_q, digit_sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             alarm_prev_q, alarm_prev_d;
    logic             rise;
    logic [3:0]       h0_max;

    always_comb begin
        state_d      = state_q;
        h1_d         = h1_q;
        h0_d         = h0_q;
        m1_d         = m1_q;
        m0_d         = m0_q;
        ld_time_d    = 1'b0;
        ld_alarm_d   = 1'b0;
        alarm_on_d   = alarm_on_q;
        buzzer_d     = buzzer_q;
        edit_mode_d  = edit_mode_q;
        digit_sel_d  = digit_sel_q;
        cnt_d        = cnt_q;
        alarm_prev_d = alarm_in;
        rise         = alarm_in & ~alarm_prev_q;
        h0_max       = (h1_q == 2'd2) ? 4'd3 : 4'd9;
        case (state_q)
            IDLE: begin
                if (btn_arm) alarm_on_d = ~alarm_on_q;
                if (rise && alarm_on_q) begin
                    state_d  = RING;
                    buzzer_d = 1'b1;
                    cnt_d    = RING_LD;
                end else if (btn_mode) begin
                    state_d     = EDIT_TIME;
                    edit_mode_d = 2'b01;
                    digit_sel_d = 2'd0;
                    h1_d        = 2'd0;
                    h0_d        = 4'd0;
                    m1_d        = 4'd0;
                    m0_d        = 4'd0;
                end
            end
            EDIT_TIME, EDIT_ALARM: begin
                if (btn_mode) begin
                    state_d     = (state_q == EDIT_TIME) ? EDIT_ALARM : IDLE;
                    edit_mode_d = (state_q == EDIT_TIME) ? 2'b10 : 2'b00;
                    digit_sel_d = 2'd0;
                    if (state_q == EDIT_TIME) begin
                        h1_d = 2'd0;
                        h0_d = 4'd0;
                        m1_d = 4'd0;
                        m0_d = 4'd0;
                    end
                end else if (btn_set) begin
                    if (digit_sel_q == 2'd3) begin
                        state_d    = LOAD;
                        ld_time_d  = (state_q == EDIT_TIME);
                        ld_alarm_d = (state_q == EDIT_ALARM);
                    end else digit_sel_d = digit_sel_q + 2'd1;
                end else if (btn_inc) begin
                    case (digit_sel_q)
                        2'd0: begin
                            h1_d = (h1_q == 2'd2) ? 2'd0 : h1_q + 2'd1;
                            // moving into the 20s must not leave an invalid hour such as 27
                            if (h1_q == 2'd1 && h0_q > 4'd3) h0_d = 4'd3;
                        end
                        2'd1: h0_d = (h0_q >= h0_max) ? 4'd0 : h0_q + 4'd1;
                        2'd2: m1_d = (m1_q >= 4'd5) ? 4'd0 : m1_q + 4'd1;
                        default: m0_d = (m0_q >= 4'd9) ? 4'd0 : m0_q + 4'd1;
                    endcase
                end
            end
            LOAD: begin
                state_d     = IDLE;
                edit_mode_d = 2'b00;
                digit_sel_d = 2'd0;
            end
            RING: begin
                if (btn_set) begin
                    state_d  = IDLE;
                    buzzer_d = 1'b0;
                end else if (btn_snooze) begin
                    state_d  = SNOOZE;
                    buzzer_d = 1'b0;
                    cnt_d    = SNOOZE_LD;
                end else if (cnt_q == '0) begin
                    state_d  = IDLE;
                    buzzer_d = 1'b0;
                end else cnt_d = cnt_q - 1'b1;
            end
            SNOOZE: begin
                if (btn_set) state_d = IDLE;
                else if (cnt_q == '0) begin
                    state_d  = RING;
                    buzzer_d = 1'b1;
                    cnt_d    = RING_LD;
                end else cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            h1_q         <= '0;
            h0_q         <= '0;
            m1_q         <= '0;
            m0_q         <= '0;
            ld_time_q    <= 1'b0;
            ld_alarm_q   <= 1'b0;
            alarm_on_q   <= 1'b0;
            buzzer_q     <= 1'b0;
            edit_mode_q  <= '0;
            digit_sel_q  <= '0;
            cnt_q        <= '0;
            alarm_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            h1_q         <= h1_d;
            h0_q         <= h0_d;
            m1_q         <= m1_d;
            m0_q         <= m0_d;
            ld_time_q    <= ld_time_d;
            ld_alarm_q   <= ld_alarm_d;
            alarm_on_q   <= alarm_on_d;
            buzzer_q     <= buzzer_d;
            edit_mode_q  <= edit_mode_d;
            digit_sel_q  <= digit_sel_d;
            cnt_q        <= cnt_d;
            alarm_prev_q <= alarm_prev_d;
        end
    end

    assign hourIn1   = h1_q;
    assign hourIn0   = h0_q;
    assign minIn1    = m1_q;
    assign minIn0    = m0_q;
    assign ldTime    = ld_time_q;
    assign ldAlarm   = ld_alarm_q;
    assign alarmOn   = alarm_on_q;
    assign buzzer    = buzzer_q;
    assign edit_mode = edit_mode_q;
    assign digit_sel = digit_sel_q;
endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed plus random stimulus checked every cycle against a behavioural model.
module tb_alarm_ctrl;
    localparam int RING = 60, SNZ = 300;
    localparam int P_IDLE = 0, P_ET = 1, P_EA = 2, P_LOAD = 3, P_RING = 4, P_SNZ = 5;

    logic clk = 1'b0, reset = 1'b1;
    logic btn_mode = 0, btn_set = 0, btn_inc = 0, btn_arm = 0, btn_snooze = 0, alarm_in = 0;
    logic [1:0] hourIn1, edit_mode, digit_sel;
    logic [3:0] hourIn0, minIn1, minIn0;
    logic ldTime, ldAlarm, alarmOn, buzzer;

    int n_tests = 0, n_fail = 0;
    int ph = P_IDLE, sel = 0, em = 0, left = 0;
    int dig[4] = '{0, 0, 0, 0};
    bit on = 0, buz = 0, lt = 0, la = 0, prev = 0;

    alarm_ctrl #(.RING_CYCLES(RING), .SNOOZE_CYCLES(SNZ), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_set(btn_set), .btn_inc(btn_inc),
        .btn_arm(btn_arm), .btn_snooze(btn_snooze), .alarm_in(alarm_in),
        .hourIn1(hourIn1), .hourIn0(hourIn0), .minIn1(minIn1), .minIn0(minIn0),
        .ldTime(ldTime), .ldAlarm(ldAlarm), .alarmOn(alarmOn), .buzzer(buzzer),
        .edit_mode(edit_mode), .digit_sel(digit_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int digit_max(input int i);
        return i == 0 ? 2 : i == 1 ? (dig[0] == 2 ? 3 : 9) : i == 2 ? 5 : 9;
    endfunction

    task automatic model_step();
        bit edge_r, was_on;
        if (reset) begin
            ph = P_IDLE; dig = '{0, 0, 0, 0}; sel = 0; em = 0; on = 0; buz = 0;
            lt = 0; la = 0; prev = 0; left = 0;
            return;
        end
        edge_r = alarm_in && !prev;
        prev = alarm_in;
        was_on = on;
        lt = 0;
        la = 0;
        case (ph)
            P_IDLE: begin
                if (btn_arm) on = !on;
                if (edge_r && was_on) begin ph = P_RING; buz = 1; left = RING; end
                else if (btn_mode) begin ph = P_ET; em = 1; sel = 0; dig = '{0, 0, 0, 0}; end
            end
            P_ET, P_EA: begin
                if (btn_mode) begin
                    if (ph == P_ET) begin ph = P_EA; em = 2; dig = '{0, 0, 0, 0}; end
                    else begin ph = P_IDLE; em = 0; end
                    sel = 0;
                end else if (btn_set) begin
                    if (sel == 3) begin lt = (ph == P_ET); la = (ph == P_EA); ph = P_LOAD; end
                    else sel++;
                end else if (btn_inc) begin
                    dig[sel] = (dig[sel] >= digit_max(sel)) ? 0 : dig[sel] + 1;
                    if (dig[0] == 2 && dig[1] > 3) dig[1] = 3;
                end
            end
            P_LOAD: begin ph = P_IDLE; em = 0; sel = 0; end
            P_RING: begin
                if (btn_set) begin ph = P_IDLE; buz = 0; end
                else if (btn_snooze) begin ph = P_SNZ; buz = 0; left = SNZ; end
                else begin
                    left--;
                    if (left == 0) begin ph = P_IDLE; buz = 0; end
                end
            end
            default: begin
                if (btn_set) ph = P_IDLE;
                else begin
                    left--;
                    if (left == 0) begin ph = P_RING; buz = 1; left = RING; end
                end
            end
        endcase
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("digits", {hourIn1, hourIn0, minIn1, minIn0}, dig[0] * 4096 + dig[1] * 256 + dig[2] * 16 + dig[3]);
        check("ld", {ldTime, ldAlarm}, {lt, la});
        check("alarmOn", alarmOn, on);
        check("buzzer", buzzer, buz);
        check("edit_mode", edit_mode, em);
        check("digit_sel", digit_sel, sel);
        btn_mode = 0; btn_set = 0; btn_inc = 0; btn_arm = 0; btn_snooze = 0;
    endtask

    task automatic enter(input int a, input int b, input int c, input int d);
        int v[4];
        v = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            repeat (v[i]) begin btn_inc = 1; cyc(); end
            btn_set = 1;
            cyc();
        end
    endtask

    task automatic ring_up();
        alarm_in = 0; cyc();
        alarm_in = 1; cyc();
    endtask

    initial begin
        int hi, lo;
        cyc(); cyc();
        reset = 0;
        check("rst_outputs", {ldTime, ldAlarm, alarmOn, buzzer, edit_mode, digit_sel}, 0);
        btn_mode = 1; cyc();
        check("et_mode", edit_mode, 1);
        enter(1, 2, 3, 4);
        check("ldtime_strobe", {ldTime, ldAlarm}, 2'b10);
        check("ldtime_digits", {hourIn1, hourIn0, minIn1, minIn0}, {2'd1, 4'd2, 4'd3, 4'd4});
        check("ldtime_mode_held", edit_mode, 1);
        cyc();
        check("ldtime_after", {ldTime, ldAlarm, edit_mode}, 0);
        btn_mode = 1; cyc(); btn_mode = 1; cyc();
        enter(2, 3, 5, 9);
        check("ldalarm_strobe", {ldTime, ldAlarm}, 2'b01);
        check("ldalarm_digits", {hourIn1, hourIn0, minIn1, minIn0}, {2'd2, 4'd3, 4'd5, 4'd9});
        cyc();
        btn_mode = 1; cyc(); btn_set = 1; cyc();
        repeat (7) begin btn_inc = 1; cyc(); end
        check("h0_seven", hourIn0, 7);
        btn_mode = 1; cyc();
        repeat (2) begin btn_inc = 1; cyc(); end
        btn_set = 1; cyc();
        repeat (3) begin btn_inc = 1; cyc(); end
        check("h0_max3", hourIn0, 3);
        btn_inc = 1; cyc();
        check("h0_wrap", hourIn0, 0);
        btn_mode = 1; cyc();
        check("abort_mode", edit_mode, 0);
        btn_mode = 1; cyc(); btn_mode = 1; cyc();
        btn_inc = 1; cyc();
        btn_mode = 1; btn_inc = 1; cyc();
        check("mode_beats_inc", {edit_mode, hourIn1}, {2'd0, 2'd1});
        btn_arm = 1; cyc();
        check("armed", alarmOn, 1);
        ring_up();
        check("ring_start", buzzer, 1);
        hi = 0;
        for (int k = 0; k < 100 && buzzer; k++) begin hi++; cyc(); end
        check("ring_len", hi, RING);
        btn_arm = 1; cyc();
        ring_up(); cyc();
        check("disarmed_no_ring", {alarmOn, buzzer}, 0);
        btn_arm = 1; cyc();
        ring_up();
        btn_snooze = 1; cyc();
        check("snooze_quiet", buzzer, 0);
        lo = 0;
        for (int k = 0; k < 400 && !buzzer; k++) begin lo++; cyc(); end
        check("snooze_len", lo, SNZ);
        check("rering", buzzer, 1);
        btn_set = 1; cyc();
        check("dismiss", buzzer, 0);
        ring_up();
        btn_set = 1; btn_snooze = 1; cyc();
        lo = 0;
        for (int k = 0; k < 320; k++) begin if (buzzer) lo++; cyc(); end
        check("set_beats_snooze", lo, 0);
        btn_mode = 1; cyc();
        enter(1, 1, 1, 0);
        reset = 1; cyc(); reset = 0;
        check("rst_in_load", {ldTime, ldAlarm, edit_mode, alarmOn}, 0);
        btn_mode = 1; cyc();
        enter(0, 0, 0, 0);
        reset = 1; cyc(); reset = 0;
        check("rst_after_strobe", {ldTime, ldAlarm, edit_mode}, 0);
        btn_arm = 1; cyc();
        ring_up(); cyc();
        reset = 1; cyc(); reset = 0;
        check("rst_in_ring", {buzzer, alarmOn, edit_mode}, 0);
        cyc();
        check("idle_after_rst", buzzer, 0);
        for (int n = 0; n < 20000; n++) begin
            reset      = ($urandom_range(0, 1999) == 0);
            btn_mode   = ($urandom_range(0, 15) == 0);
            btn_set    = ($urandom_range(0, 15) == 0);
            btn_inc    = ($urandom_range(0, 3) == 0);
            btn_arm    = ($urandom_range(0, 15) == 0);
            btn_snooze = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 39) == 0) alarm_in = !alarm_in;
            cyc();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1);
    end
endmodule
